player_ctrl: RTL
================

# player_ctrl

Game-level sequencer for the player-motion datapath. Owns the run/dead state machine, generates the per-step movement enable, decides gravity direction from the flip button, detects death at screen limits and keeps a distance score. Sits between the debounced buttons and the player-height datapath, whose `grav_dir`, `is_dead` and active-low reset it drives.

## Interface
- `TICK_DIV`, default 100000: clk cycles per movement step; legal range ≥2.
- `Y_MIN`, default 0: player top-edge height at which upward fall is fatal.
- `Y_MAX`, default 420: player top-edge height at which downward fall is fatal (480 − 60 px player).
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-low.
- `btn_start`, in, 1: debounced start/restart level.
- `btn_flip`, in, 1: debounced gravity-flip level.
- `height`, in, 9: current player top-edge height from the datapath.
- `lines`, in, 3: ground present at 120/240/360 under the player; bit0 = 120, bit1 = 240, bit2 = 360.
- `grav_dir`, out, 1: 0 = down, 1 = up.
- `is_dead`, out, 1: freeze to the datapath.
- `player_rst_n`, out, 1: active-low reset to the datapath.
- `move_en`, out, 1: one-cycle step strobe.
- `score`, out, 16: steps survived.
- `state`, out, 2: IDLE = 0, RUN = 1, DEAD = 2.

## Operation
- **Edge detection:** rising edges of `btn_start` and `btn_flip` come from one-cycle-delayed copies. A held button produces one event.
- **IDLE:**
  - Outputs: `is_dead` = 1, `grav_dir` = 0, `move_en` = 0.
  - A start edge moves to RUN. In that cycle `player_rst_n` = 0, `score` clears to 0 and the divider clears to 0.
- **RUN:**
  - Outputs: `is_dead` = 0.
  - The divider counts 0..`TICK_DIV`−1. `move_en` = 1 in the cycle the count equals `TICK_DIV`−1, then the count wraps to 0.
  - `score` increments on each `move_en` and saturates at 16'hFFFF.
- **Grounded:** true when either condition holds:
  - `grav_dir` = 0 and ((`height` == 180 & `lines[1]`) | (`height` == 300 & `lines[2]`)).
  - `grav_dir` = 1 and ((`height` == 120 & `lines[0]`) | (`height` == 240 & `lines[1]`)).
- **Flip:** a flip edge while grounded toggles `grav_dir` on the next clock. A flip edge while airborne is handled as described in Configuration.
- **Death:** RUN moves to DEAD when `height` ≥ `Y_MAX` with `grav_dir` = 0, or `height` ≤ `Y_MIN` with `grav_dir` = 1.
  - If death and a flip happen in the same cycle, death wins and `grav_dir` holds.
- **DEAD:**
  - Outputs: `is_dead` = 1; `grav_dir` and `score` hold.
  - A start edge moves to IDLE. A second start edge is then needed to run.
- **Ignored inputs:** a start edge in RUN is ignored, and a flip edge in IDLE or DEAD is ignored.
- **Out-of-range state:** an illegal `state` encoding returns to IDLE.

## Timing
- **Reset** (`reset` = 0 sampled at `clk`) forces:
  - `state` = IDLE, `grav_dir` = 0, `is_dead` = 1, `player_rst_n` = 0.
  - `move_en` = 0, `score` = 0, divider = 0, edge registers = 0.
- **After reset:** `player_rst_n` returns to 1 on the first clock after `reset` deasserts.
- **Reset mid-RUN:** takes effect on the next edge; no step strobe is emitted in that cycle.
- **Start latency:** a `btn_start` rise at edge N gives `state` = RUN after edge N+1 (the edge-register delay plus the FSM register).
  - `player_rst_n` is low for exactly the one cycle following that edge.
  - The first `move_en` comes `TICK_DIV` cycles after entry to RUN.
- **Flip latency:** `grav_dir` changes 2 clocks after the `btn_flip` rise.
- **Death latency:** `is_dead` rises 1 clock after the limit height is presented. No `move_en` is emitted in or after that cycle.
- All outputs are registered.

## Configuration
- **`PLAYER_CTRL_FLIP_BUFFER_EN` defined:**
  - A flip edge while airborne in RUN sets a pending flag.
  - The flag is applied, and cleared, in the first grounded RUN cycle, toggling `grav_dir` as a normal flip.
  - The flag clears on leaving RUN and on reset.
  - A second airborne flip edge does not cancel a pending flip.
- **Not defined:** airborne flip edges are discarded. No pending register exists.

## Structure
- **Shared package `player_pkg`:**
  - State encoding constants: `ST_IDLE`, `ST_RUN`, `ST_DEAD`.
  - Line heights 120/240/360, player height 60, and the derived rest heights 120/180/240/300.
  - Default `Y_MIN`/`Y_MAX`.
- **Sub-module `step_divider`:**
  - Clear input, enable input, one-cycle terminal-count output, parameterised by `TICK_DIV`.
  - Instantiated once.
- The grounded check and the FSM stay in `player_ctrl`.

## Test plan
- **Reset and start:** `TICK_DIV` = 4. Hold reset low 3 cycles, then pulse `btn_start`.
  - `state` goes 0→1 two clocks after the rise.
  - `player_rst_n` is low for one cycle.
  - `move_en` pulses every 4 cycles and `score` counts 1, 2, 3.
- **Grounded flip:** RUN, `grav_dir` = 0, `height` = 180, `lines` = 3'b010. Pulse `btn_flip`.
  - `grav_dir` = 1 two clocks later. Holding the button produces no second toggle.
- **Airborne flip:** `height` = 200, then `height` = 240 with `lines[1]` = 1 under up gravity.
  - Macro off: `grav_dir` is unchanged.
  - Macro on: `grav_dir` toggles the cycle after grounded is reached.
- **Death:** RUN, `grav_dir` = 0, `height` = 420, with a flip edge in the same cycle.
  - `state` = 2, `is_dead` = 1, `grav_dir` stays 0, `score` frozen, `move_en` stays 0.
- **Saturation and restart:** preload `score` near 16'hFFFF and run 5 steps.
  - `score` holds at FFFF.
  - Start edge in DEAD → IDLE; second start edge → RUN with `score` = 0.

Source files
------------

// File: rtl/player_pkg.sv
// Shared constants for the player-motion sequencer: state encoding,
// line and rest heights, and default screen limits.
package player_pkg;

  // Sequencer state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  // Ground lines and player size, in pixels from the top of the screen.
  localparam int unsigned LINE_Y0  = 120;
  localparam int unsigned LINE_Y1  = 240;
  localparam int unsigned LINE_Y2  = 360;
  localparam int unsigned PLAYER_H = 60;

  // Rest heights of the player's top edge.
  // Under up gravity the player hangs with its top edge on a line.
  // Under down gravity it stands with its bottom edge on a line.
  localparam int unsigned REST_UP_0 = LINE_Y0;
  localparam int unsigned REST_UP_1 = LINE_Y1;
  localparam int unsigned REST_DN_1 = LINE_Y1 - PLAYER_H;
  localparam int unsigned REST_DN_2 = LINE_Y2 - PLAYER_H;

  // Default fatal limits (480 line screen, 60 px player).
  localparam int unsigned Y_MIN_DEF = 0;
  localparam int unsigned Y_MAX_DEF = 420;

  // Truncate a pixel constant to the 9-bit height bus.
  function automatic logic [8:0] to_h9(input int unsigned v);
    return v[8:0];
  endfunction

endpackage

// File: rtl/player_ctrl_step_divider.sv
// Movement-step divider: counts 0..TICK_DIV-1 while enabled and flags the
// terminal count for one cycle as it wraps. Clear forces the count to 0.
module step_divider #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tc = en & (count == LAST);

  // Up-counter with wrap at the terminal count.
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/player_ctrl.sv
// Player game sequencer: run/dead FSM, step strobe, gravity flip,
// death at screen limits and distance score.
// Optional: define PLAYER_CTRL_FLIP_BUFFER_EN to remember a flip pressed
// in the air and apply it on the next landing.
//
//  state | meaning
//  IDLE  | waiting for start, datapath frozen
//  RUN   | stepping, flips accepted, limits watched
//  DEAD  | frozen at death, score held until start
module player_ctrl
  import player_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned Y_MIN    = Y_MIN_DEF,
  parameter int unsigned Y_MAX    = Y_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_flip,
  input  logic [8:0]  height,
  input  logic [2:0]  lines,
  output logic        grav_dir,
  output logic        is_dead,
  output logic        player_rst_n,
  output logic        move_en,
  output logic [15:0] score,
  output logic [1:0]  state
);

  localparam logic [8:0] H_UP0 = to_h9(REST_UP_0);
  localparam logic [8:0] H_UP1 = to_h9(REST_UP_1);
  localparam logic [8:0] H_DN1 = to_h9(REST_DN_1);
  localparam logic [8:0] H_DN2 = to_h9(REST_DN_2);
  localparam logic [8:0] H_MIN = to_h9(Y_MIN);
  localparam logic [8:0] H_MAX = to_h9(Y_MAX);

  logic        start_q, flip_q;
  logic        start_ev, flip_ev;
  logic        grounded, dying, tc;
  logic        div_en, div_clr;
  logic [1:0]  state_nx;
  logic        grav_nx, prst_nx;
  logic [15:0] score_nx;
  logic        pend, pend_nx;

  // Registered rising-edge pulses of the debounced buttons.
  always_ff @(posedge clk) begin
    if (!reset) begin
      start_q  <= 1'b0;
      flip_q   <= 1'b0;
      start_ev <= 1'b0;
      flip_ev  <= 1'b0;
    end else begin
      start_q  <= btn_start;
      flip_q   <= btn_flip;
      start_ev <= btn_start & ~start_q;
      flip_ev  <= btn_flip & ~flip_q;
    end
  end

  // Player is resting on a line in the current gravity direction.
  always_comb begin
    if (grav_dir)
      grounded = ((height == H_UP0) && lines[0]) || ((height == H_UP1) && lines[1]);
    else
      grounded = ((height == H_DN1) && lines[1]) || ((height == H_DN2) && lines[2]);
  end

  // Falling past the screen edge in the current gravity direction.
  always_comb begin
    dying = 1'b0;
    if (state == ST_RUN)
      dying = grav_dir ? (height <= H_MIN) : (height >= H_MAX);
  end

  // Steps only run while alive; the count restarts from 0 on every entry.
  assign div_en  = (state == ST_RUN) & ~dying;
  assign div_clr = (state != ST_RUN);

  step_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .clr   (div_clr),
    .en    (div_en),
    .tc    (tc)
  );

  // Next-state, gravity, score and datapath-reset decisions.
  always_comb begin
    state_nx = state;
    grav_nx  = grav_dir;
    score_nx = score;
    prst_nx  = 1'b1;
    pend_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        grav_nx = 1'b0;
        if (start_ev) begin
          state_nx = ST_RUN;
          score_nx = 16'd0;
          prst_nx  = 1'b0;
        end
      end
      ST_RUN: begin
        if (dying) begin
          // Death outranks a simultaneous flip; gravity holds.
          state_nx = ST_DEAD;
        end else begin
          if (tc && (score != 16'hFFFF))
            score_nx = score + 16'd1;
`ifdef PLAYER_CTRL_FLIP_BUFFER_EN
          if (grounded) begin
            if (flip_ev || pend)
              grav_nx = ~grav_dir;
          end else begin
            pend_nx = pend | flip_ev;
          end
`else
          if (flip_ev && grounded)
            grav_nx = ~grav_dir;
`endif
        end
      end
      ST_DEAD: begin
        if (start_ev) begin
          state_nx = ST_IDLE;
          grav_nx  = 1'b0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        grav_nx  = 1'b0;
      end
    endcase
  end

`ifdef PLAYER_CTRL_FLIP_BUFFER_EN
  // Airborne flip memory; dropped whenever RUN is left.
  always_ff @(posedge clk) begin
    if (!reset) pend <= 1'b0;
    else        pend <= pend_nx;
  end
`else
  assign pend = 1'b0;
`endif

  // Output and state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      grav_dir     <= 1'b0;
      is_dead      <= 1'b1;
      player_rst_n <= 1'b0;
      move_en      <= 1'b0;
      score        <= 16'd0;
    end else begin
      state        <= state_nx;
      grav_dir     <= grav_nx;
      is_dead      <= (state_nx != ST_RUN);
      player_rst_n <= prst_nx;
      move_en      <= tc;
      score        <= score_nx;
    end
  end

endmodule
